bus_arbiter_nx1: RTL
====================

Name: bus_arbiter_nx1

Overview:
- N-requester to single-bus arbiter; the parametrised successor of the fixed 2-input arbiter.
- Sits between per-hart/per-DMA bus masters (instruction/data bus adapters) and the shared system bus.
- Round-robin grant. The grant is held for a whole transaction until the slave acks.
- Adds aborted-request handling and an optional slave-timeout watchdog.

Parameters:
- N_PORTS, 4, number of requesters (2..16).
- XLEN, 32, address/data width.
- TIMEOUT, 255, cycles in BUSY before forced completion (used only with the macro).

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_bus_en  in  N_PORTS  per-requester transaction request, held until its ack.
- i_wr_rd  in  N_PORTS  per-requester 1=write, 0=read.
- i_wr_data  in  N_PORTS*XLEN  flattened write data; port k uses bits [k*XLEN +: XLEN].
- i_addr  in  N_PORTS*XLEN  flattened address.
- i_size  in  N_PORTS*3  flattened access size (funct3 encoding).
- o_ack  out  N_PORTS  one-hot completion pulse to the granted requester.
- o_rd_data  out  XLEN  read data, broadcast; valid only where o_ack is set.
- o_timeout  out  N_PORTS  one-hot pulse when completion was forced by the watchdog.
- i_ack  in  1  slave completion.
- i_rd_data  in  XLEN  slave read data.
- o_bus_en  out  1  request to the shared bus.
- o_wr_rd  out  1  muxed write/read flag.
- o_wr_data  out  XLEN  muxed write data.
- o_addr  out  XLEN  muxed address.
- o_size  out  3  muxed access size.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, grant=0, last=N_PORTS-1, so port 0 wins first.
  - All outputs 0.
- IDLE:
  - If any i_bus_en bit is set, the winner is the first set bit searching upward from last+1, wrapping modulo N_PORTS.
  - grant<=winner, last<=winner, state<=BUSY.
  - No bus outputs are driven in IDLE; o_bus_en=0.
- BUSY:
  - o_bus_en=i_bus_en[grant].
  - o_wr_rd/o_wr_data/o_addr/o_size are combinationally muxed from the granted port.
  - Non-granted inputs are ignored.
- Latency: request seen in cycle 0 -> o_bus_en high in cycle 1 (registered grant).
- Completion:
  - In BUSY with i_ack=1: o_ack[grant]=1 and o_rd_data=i_rd_data in the same cycle (combinational); state<=IDLE.
  - Mandatory one idle cycle between transactions.
- Back-to-back: a requester still asserting i_bus_en after its ack competes again; round-robin puts it last.
- Abort: in BUSY, if i_bus_en[grant] drops before i_ack, then o_bus_en drops the same cycle, no o_ack is issued, and state<=IDLE.
- Spurious ack: i_ack in IDLE is ignored; o_ack stays 0.
- Simultaneous requests in IDLE resolve by round-robin only; there are no priorities.
- o_rd_data=0 whenever o_ack is all-zero.
- Reset mid-BUSY: immediate return to IDLE. No ack is generated and the in-flight transaction is lost.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8..16-bit counter clears on entering BUSY and increments each BUSY cycle without i_ack.
  - When the count reaches TIMEOUT: o_ack[grant]=1, o_timeout[grant]=1, o_rd_data=0, o_bus_en=0, state<=IDLE.
  - A real i_ack in the same cycle takes precedence: normal ack, no timeout.
- Undefined: no counter; o_timeout tied to 0; BUSY waits indefinitely.

Decomposition:
- Shared package/defines header:
  - XLEN.
  - Size encodings (BYTE=3'b000, HALF=3'b001, WORD=3'b010, BYTE_U=3'b100, HALF_U=3'b101).
  - State encoding ARB_IDLE/ARB_BUSY.
- Sub-module arb_rr_pick: combinational round-robin picker.
  - Inputs: request vector, last pointer.
  - Outputs: winner index and valid.
  - Reused later by the interrupt controller.

Test Plan:
- Single read: after reset, port 2 requests addr=0x8000_0010, size=3'b010; slave acks 3 cycles after o_bus_en with rd_data=0x1234_5678 -> o_bus_en rises 1 cycle after request; o_addr=0x8000_0010; o_ack=4'b0100 and o_rd_data=0x1234_5678 in the ack cycle.
- Fairness: ports 0–3 all hold i_bus_en; slave acks immediately each transaction -> grant order 0,1,2,3,0,1; every grant is separated by exactly one IDLE cycle.
- Write mux: port 1 writes 0xDEAD_BEEF to 0x2000_0004 while port 3 holds a read pending -> bus shows port 1's write only; port 3 is granted next with its own address.
- Abort: port 0 granted, drops i_bus_en before ack -> o_bus_en falls the same cycle, o_ack stays 0, and the next requester is granted 2 cycles later.
- Async reset during BUSY: i_rst_n low mid-transaction -> all outputs 0 without a clock edge; after release, port 0 wins first.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=8): slave never acks port 1 -> after 8 BUSY cycles o_ack=4'b0010, o_timeout=4'b0010, o_rd_data=0. Repeat with i_ack arriving in the 8th cycle -> normal ack, o_timeout=0.

Source files
------------

// File: rtl/bus_arbiter_nx1_pkg.sv
// Shared definitions for the N-to-1 round-robin bus arbiter.
// Covers the data width, the access-size (funct3) encodings and the FSM state encoding.
package bus_arbiter_nx1_pkg;

    localparam int unsigned ARB_XLEN = 32;

    localparam logic [2:0] SIZE_BYTE   = 3'b000;
    localparam logic [2:0] SIZE_HALF   = 3'b001;
    localparam logic [2:0] SIZE_WORD   = 3'b010;
    localparam logic [2:0] SIZE_BYTE_U = 3'b100;
    localparam logic [2:0] SIZE_HALF_U = 3'b101;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational round-robin picker: the first set request bit strictly after 'last',
// wrapping modulo N_PORTS. It is kept free of bus-specific logic so other blocks can reuse it.
module arb_rr_pick #(
    parameter int unsigned N_PORTS = 4,
    localparam int unsigned IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
    input  logic [N_PORTS-1:0] req,
    input  logic [IW-1:0]      last,
    output logic [IW-1:0]      winner,
    output logic               valid
);

    logic [IW-1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = last;
        // Visit last+1 .. last+N_PORTS, so 'last' itself is checked at the very end.
        for (int unsigned i = 0; i < N_PORTS; i++) begin
            idx = (idx == IW'(N_PORTS - 1)) ? '0 : idx + IW'(1);
            if (!valid && req[idx]) begin
                valid  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_nx1.sv
// N-requester to single-bus round-robin arbiter; the grant is held until the slave acks or the request aborts.
// Define ARB_TIMEOUT_EN to add the slave-timeout watchdog that forces completion after TIMEOUT BUSY cycles.
module bus_arbiter_nx1
    import bus_arbiter_nx1_pkg::*;
#(
    parameter int unsigned N_PORTS = 4,
    parameter int unsigned XLEN    = ARB_XLEN,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [N_PORTS-1:0]      i_bus_en,
    input  logic [N_PORTS-1:0]      i_wr_rd,
    input  logic [N_PORTS*XLEN-1:0] i_wr_data,
    input  logic [N_PORTS*XLEN-1:0] i_addr,
    input  logic [N_PORTS*3-1:0]    i_size,
    output logic [N_PORTS-1:0]      o_ack,
    output logic [XLEN-1:0]         o_rd_data,
    output logic [N_PORTS-1:0]      o_timeout,
    input  logic                    i_ack,
    input  logic [XLEN-1:0]         i_rd_data,
    output logic                    o_bus_en,
    output logic                    o_wr_rd,
    output logic [XLEN-1:0]         o_wr_data,
    output logic [XLEN-1:0]         o_addr,
    output logic [2:0]              o_size
);

    localparam int unsigned IW = $clog2(N_PORTS);

    if (N_PORTS < 2 || N_PORTS > 16 || TIMEOUT == 0 || TIMEOUT > 65535) begin : g_param_check
        $error("bus_arbiter_nx1: unsupported parameter value");
    end

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] pick_winner;
    logic          pick_valid;
    logic          req_live;
    logic          timeout_hit;

    logic [XLEN-1:0] wr_data_arr [N_PORTS];
    logic [XLEN-1:0] addr_arr    [N_PORTS];
    logic [2:0]      size_arr    [N_PORTS];

    for (genvar k = 0; k < N_PORTS; k++) begin : g_unpack
        assign wr_data_arr[k] = i_wr_data[k*XLEN +: XLEN];
        assign addr_arr[k]    = i_addr[k*XLEN +: XLEN];
        assign size_arr[k]    = i_size[k*3 +: 3];
    end

    arb_rr_pick #(
        .N_PORTS (N_PORTS)
    ) u_pick (
        .req    (i_bus_en),
        .last   (last_q),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    assign req_live = i_bus_en[grant_q];

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT < 256) ? 8 : 16;

    logic [CW-1:0] cnt_q, cnt_d;

    // cnt_q counts completed ack-less BUSY cycles, so the TIMEOUT-th BUSY cycle sees TIMEOUT-1.
    assign timeout_hit = (state_q == ARB_BUSY) && (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ARB_IDLE) begin
            cnt_d = '0;
        end else if (!i_ack) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        o_bus_en  = 1'b0;
        o_wr_rd   = 1'b0;
        o_wr_data = '0;
        o_addr    = '0;
        o_size    = '0;
        o_ack     = '0;
        o_rd_data = '0;
        o_timeout = '0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_winner;
                    last_d  = pick_winner;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                o_bus_en  = req_live;
                o_wr_rd   = i_wr_rd[grant_q];
                o_wr_data = wr_data_arr[grant_q];
                o_addr    = addr_arr[grant_q];
                o_size    = size_arr[grant_q];
                // A real ack wins over both abort and watchdog expiry.
                if (i_ack) begin
                    o_ack[grant_q] = 1'b1;
                    o_rd_data      = i_rd_data;
                    state_d        = ARB_IDLE;
                end else if (!req_live) begin
                    state_d = ARB_IDLE;
                end else if (timeout_hit) begin
                    o_bus_en           = 1'b0;
                    o_ack[grant_q]     = 1'b1;
                    o_timeout[grant_q] = 1'b1;
                    state_d            = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IW'(N_PORTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

endmodule
